// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared constants and types for the HDMI output path.
//   TMDS_W           - encoded TMDS word width
//   CTRL_TOKEN_00..11 - TMDS control-period tokens (C1,C0 = 00..11)
//   link_state_e     - link sequencer FSM states
//   max3()           - helper for sizing counters from parameters
package hdmi_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_SRST,
        ST_FLUSH,
        ST_RUN
    } link_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for W independent asynchronous bits.
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset, clears both stages
//   d_i   - asynchronous inputs
//   q_o   - synchronised outputs (2 cycles latency)
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tmds_link_sequencer.sv
// tmds_link_sequencer: startup / recovery controller for the TMDS serializers.
// Holds the serializers in reset until the clock generator lock has been
// stable, pulses serializer reset, flushes the link with control tokens and
// then passes encoder words through (registered, 1 cycle latency).
//
// Ports:
//   PixelClk            - sole clock
//   aRst                - asynchronous active-high reset
//   aLocked             - clock-generator lock (async)
//   aHpd                - sink hot-plug detect (async), only with HDMI_HPD_RESTART_EN
//   pTmdsIn0/1/2        - encoded words from the TMDS encoders
//   pTmdsOut0/1/2       - words to the serializers
//   pSerdesRst          - serializer reset, active-high
//   pLinkUp             - high while in RUN
//
// Optional feature: define HDMI_HPD_RESTART_EN to add aHpd; loss of HPD in
// FLUSH/RUN restarts the sequence and leaving WAIT_LOCK also requires HPD.
module tmds_link_sequencer
    import hdmi_pkg::*;
#(
    parameter int kLockStableCycles = 1024,
    parameter int kSerdesRstCycles  = 16,
    parameter int kFlushCycles      = 64
) (
    input  logic              PixelClk,
    input  logic              aRst,
    input  logic              aLocked,
`ifdef HDMI_HPD_RESTART_EN
    input  logic              aHpd,
`endif
    input  logic [TMDS_W-1:0] pTmdsIn0,
    input  logic [TMDS_W-1:0] pTmdsIn1,
    input  logic [TMDS_W-1:0] pTmdsIn2,
    output logic [TMDS_W-1:0] pTmdsOut0,
    output logic [TMDS_W-1:0] pTmdsOut1,
    output logic [TMDS_W-1:0] pTmdsOut2,
    output logic              pSerdesRst,
    output logic              pLinkUp
);

    localparam int CNT_W = $clog2(max3(kLockStableCycles, kSerdesRstCycles, kFlushCycles)) + 1;

    localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(kLockStableCycles - 1);
    localparam logic [CNT_W-1:0] SRST_TC  = CNT_W'(kSerdesRstCycles - 1);
    localparam logic [CNT_W-1:0] FLUSH_TC = CNT_W'(kFlushCycles - 1);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic pLockedS;
    logic pHpdS;

`ifdef HDMI_HPD_RESTART_EN
    logic [1:0] sync_s;

    sync_2ff #(.W(2)) u_sync (
        .clk_i (PixelClk),
        .rst_i (aRst),
        .d_i   ({aHpd, aLocked}),
        .q_o   (sync_s)
    );

    assign pLockedS = sync_s[0];
    assign pHpdS    = sync_s[1];
`else
    sync_2ff #(.W(1)) u_sync (
        .clk_i (PixelClk),
        .rst_i (aRst),
        .d_i   (aLocked),
        .q_o   (pLockedS)
    );

    assign pHpdS = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM + shared counter
    // ------------------------------------------------------------------
    link_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                          serdes_rst_q, serdes_rst_d;
    logic                          link_up_q, link_up_d;
    logic [2:0][TMDS_W-1:0]        out_q, out_d;
    logic [2:0][TMDS_W-1:0]        tmds_in;

    assign tmds_in = {pTmdsIn2, pTmdsIn1, pTmdsIn0};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_LOCK: if (pLockedS && pHpdS)   state_d = ST_STABLE;
            ST_STABLE:    if (cnt_q == LOCK_TC)    state_d = ST_SRST;
            ST_SRST:      if (cnt_q == SRST_TC)    state_d = ST_FLUSH;
            ST_FLUSH:     if (cnt_q == FLUSH_TC)   state_d = ST_RUN;
            ST_RUN:       state_d = ST_RUN;
            default:      state_d = ST_WAIT_LOCK;
        endcase

        // Lock loss overrides any terminal-count transition above.
        if (!pLockedS)
            state_d = ST_WAIT_LOCK;
`ifdef HDMI_HPD_RESTART_EN
        if (!pHpdS && (state_q == ST_FLUSH || state_q == ST_RUN))
            state_d = ST_WAIT_LOCK;
`endif

        // Counter clears on every state entry; it only runs in the timed
        // states, so it stays at zero in WAIT_LOCK and RUN and cannot wrap.
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == ST_STABLE || state_q == ST_SRST || state_q == ST_FLUSH))
            cnt_d = cnt_q + 1'b1;

        // Outputs decoded from the next state so they move with the state.
        serdes_rst_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                       (state_d == ST_SRST);
        link_up_d    = (state_d == ST_RUN);
        out_d        = (state_d == ST_RUN) ? tmds_in
                                           : {3{CTRL_TOKEN_00}};
    end

    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            serdes_rst_q <= 1'b1;
            link_up_q    <= 1'b0;
            out_q        <= {3{CTRL_TOKEN_00}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            serdes_rst_q <= serdes_rst_d;
            link_up_q    <= link_up_d;
            out_q        <= out_d;
        end
    end

    assign pSerdesRst = serdes_rst_q;
    assign pLinkUp    = link_up_q;
    assign pTmdsOut0  = out_q[0];
    assign pTmdsOut1  = out_q[1];
    assign pTmdsOut2  = out_q[2];

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Directed bench for tmds_link_sequencer. A default-parameter instance covers
// startup, pass-through, lock loss and async reset; a small instance
// (4/2/3 cycles) covers lock loss exactly on the STABLE terminal count.
module tb_tmds_link_sequencer;
    import hdmi_pkg::*;

    localparam logic [9:0] TOK = 10'b1101010100;
    // Edges from the lock-rise drive point to serializer-reset release:
    // 2 sync + 1 WAIT->STABLE + kLockStable + kSerdesRst.
    localparam int MAIN_FALL  = 3 + 1024 + 16;
    localparam int MAIN_FLUSH = 64;
    localparam int SM_FALL    = 3 + 4 + 2;
    localparam int SM_FLUSH   = 3;

    logic       PixelClk = 1'b0;
    logic       aRst;
    logic       p_lock, s_lock, hpd_in;
    logic [9:0] tin0, tin1, tin2;
    logic [9:0] p_o0, p_o1, p_o2, s_o0, s_o1, s_o2;
    logic       p_srst, p_lup, s_srst, s_lup;

    int tests = 0;
    int fails = 0;

    always #5 PixelClk = ~PixelClk;

    tmds_link_sequencer dut (
        .PixelClk  (PixelClk),
        .aRst      (aRst),
        .aLocked   (p_lock),
`ifdef HDMI_HPD_RESTART_EN
        .aHpd      (hpd_in),
`endif
        .pTmdsIn0  (tin0),
        .pTmdsIn1  (tin1),
        .pTmdsIn2  (tin2),
        .pTmdsOut0 (p_o0),
        .pTmdsOut1 (p_o1),
        .pTmdsOut2 (p_o2),
        .pSerdesRst(p_srst),
        .pLinkUp   (p_lup)
    );

    tmds_link_sequencer #(
        .kLockStableCycles(4),
        .kSerdesRstCycles (2),
        .kFlushCycles     (3)
    ) dut_s (
        .PixelClk  (PixelClk),
        .aRst      (aRst),
        .aLocked   (s_lock),
`ifdef HDMI_HPD_RESTART_EN
        .aHpd      (hpd_in),
`endif
        .pTmdsIn0  (tin0),
        .pTmdsIn1  (tin1),
        .pTmdsIn2  (tin2),
        .pTmdsOut0 (s_o0),
        .pTmdsOut1 (s_o1),
        .pTmdsOut2 (s_o2),
        .pSerdesRst(s_srst),
        .pLinkUp   (s_lup)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PixelClk);
            #1;
        end
    endtask

    // Walks one startup sequence from the current point (lock already high
    // or just released from reset) and checks release edge, flush length
    // and that the token is held whenever the link is down.
    task automatic run_seq(input string nm, input bit sm, input int exp_fall, input int exp_flush);
        int fall, up, bad;
        logic srst, lup;
        logic [9:0] a, b, c;
        fall = -1; up = -1; bad = 0;
        for (int n = 1; n <= exp_fall + exp_flush + 20 && up < 0; n++) begin
            step(1);
            srst = sm ? s_srst : p_srst;
            lup  = sm ? s_lup  : p_lup;
            a = sm ? s_o0 : p_o0; b = sm ? s_o1 : p_o1; c = sm ? s_o2 : p_o2;
            if (fall < 0 && !srst) fall = n;
            if (up < 0 && lup) up = n;
            if (!lup && (a !== TOK || b !== TOK || c !== TOK)) bad++;
            if (fall >= 0 && srst) bad++;
        end
        tests++;
        if (fall !== exp_fall) begin
            fails++;
            $display("FAIL %s_srst_release: edge %0d, expected %0d", nm, fall, exp_fall);
        end
        tests++;
        if (up - fall !== exp_flush || up < 0) begin
            fails++;
            $display("FAIL %s_flush_len: got %0d (up=%0d), expected %0d", nm, up - fall, up, exp_flush);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL %s_token_hold: %0d bad cycles, expected 0", nm, bad);
        end
    endtask

    task automatic test_reset();
        aRst = 1'b1; p_lock = 0; s_lock = 0; hpd_in = 1;
        tin0 = '0; tin1 = '0; tin2 = '0;
        step(3);
        tests++;
        if ({p_srst, p_lup, p_o0, p_o1, p_o2} !== {1'b1, 1'b0, TOK, TOK, TOK}) begin
            fails++;
            $display("FAIL reset_values: srst=%b lup=%b o=%h/%h/%h, expected 1 0 %h", p_srst, p_lup, p_o0, p_o1, p_o2, TOK);
        end
        aRst = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                step(1);
                if ({p_srst, p_lup, p_o0, p_o1, p_o2, s_srst, s_lup} !== {1'b1, 1'b0, TOK, TOK, TOK, 1'b1, 1'b0}) bad++;
            end
            tests++;
            if (bad !== 0) begin
                fails++;
                $display("FAIL no_lock_idle: %0d bad cycles, expected 0", bad);
            end
        end
    endtask

    task automatic test_stable_terminal_loss();
        int bad;
        s_lock = 1;
        step(4);
        s_lock = 0;                 // seen by the FSM on the terminal cycle
        step(2);
        tests++;
        if (dut_s.state_q !== ST_STABLE || dut_s.cnt_q !== 4'd3) begin
            fails++;
            $display("FAIL term_align: state=%0d cnt=%0d, expected STABLE cnt 3", dut_s.state_q, dut_s.cnt_q);
        end
        step(1);
        tests++;
        if (dut_s.state_q !== ST_WAIT_LOCK) begin
            fails++;
            $display("FAIL term_loss_prio: state=%0d, expected WAIT_LOCK", dut_s.state_q);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (dut_s.state_q === ST_SRST || s_srst !== 1'b1) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL term_never_srst: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_small_seq();
        s_lock = 1;
        run_seq("small", 1'b1, SM_FALL, SM_FLUSH);
    endtask

    task automatic test_startup();
        p_lock = 1;
        run_seq("startup", 1'b0, MAIN_FALL, MAIN_FLUSH);
    endtask

    task automatic test_passthrough();
        logic [29:0] vec [3];
        logic [29:0] prev;
        vec[0] = {10'h3FF, 10'h155, 10'h2AA};
        vec[1] = {10'h2AA, 10'h3FF, 10'h000};
        vec[2] = {10'h30C, 10'h0F0, 10'h1AB};
        prev = {tin2, tin1, tin0};
        for (int i = 0; i < 3; i++) begin
            {tin2, tin1, tin0} = vec[i];
            #1;
            tests++;
            if ({p_o2, p_o1, p_o0} !== prev) begin
                fails++;
                $display("FAIL pass_latency%0d: out=%h, expected %h", i, {p_o2, p_o1, p_o0}, prev);
            end
            step(1);
            tests++;
            if ({p_o2, p_o1, p_o0} !== vec[i] || p_lup !== 1'b1) begin
                fails++;
                $display("FAIL pass_follow%0d: out=%h lup=%b, expected %h 1", i, {p_o2, p_o1, p_o0}, p_lup, vec[i]);
            end
            prev = vec[i];
        end
    endtask

    task automatic test_lock_loss();
        p_lock = 0;
        step(2);
        tests++;
        if (p_lup !== 1'b1) begin
            fails++;
            $display("FAIL loss_sync_lat: lup=%b, expected 1", p_lup);
        end
        step(1);
        tests++;
        if ({p_lup, p_srst, p_o0, p_o1, p_o2} !== {1'b0, 1'b1, TOK, TOK, TOK}) begin
            fails++;
            $display("FAIL loss_drop: lup=%b srst=%b o0=%h, expected 0 1 %h", p_lup, p_srst, p_o0, TOK);
        end
        step(5);
        p_lock = 1;
        run_seq("relock", 1'b0, MAIN_FALL, MAIN_FLUSH);
    endtask

    task automatic test_async_reset();
        p_lock = 0;
        step(4);
        p_lock = 1;
        step(MAIN_FALL + 10);
        tests++;
        if ({p_srst, p_lup} !== 2'b00) begin
            fails++;
            $display("FAIL flush_reached: srst=%b lup=%b, expected 0 0", p_srst, p_lup);
        end
        #2 aRst = 1'b1;
        #1;
        tests++;
        if ({p_srst, p_lup, p_o0, p_o1, p_o2} !== {1'b1, 1'b0, TOK, TOK, TOK}) begin
            fails++;
            $display("FAIL async_rst: srst=%b lup=%b o0=%h, expected 1 0 %h", p_srst, p_lup, p_o0, TOK);
        end
        step(2);
        aRst = 1'b0;
        run_seq("after_rst", 1'b0, MAIN_FALL, MAIN_FLUSH);
    endtask

`ifdef HDMI_HPD_RESTART_EN
    task automatic test_hpd();
        int bad;
        hpd_in = 0;
        step(3);
        tests++;
        if (p_lup !== 1'b0 || p_srst !== 1'b1) begin
            fails++;
            $display("FAIL hpd_drop: lup=%b srst=%b, expected 0 1", p_lup, p_srst);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (dut.state_q !== ST_WAIT_LOCK) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL hpd_hold_wait: %0d bad cycles, expected 0", bad);
        end
        hpd_in = 1;
        run_seq("hpd_back", 1'b0, MAIN_FALL, MAIN_FLUSH);
    endtask
`endif

    initial begin
        test_reset();
        test_stable_terminal_loss();
        test_small_seq();
        test_startup();
        test_passthrough();
        test_lock_loss();
        test_async_reset();
`ifdef HDMI_HPD_RESTART_EN
        test_hpd();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tmds_link_sequencer.md
Name: tmds_link_sequencer

Overview:
- Startup and recovery controller for the three TMDS output serializer channels plus the clock channel.
- Watches the pixel/serial clock generator's lock, holds the serializers in reset until clocks are stable, then flushes the link with control tokens, then passes encoder words through.
- Sits between the TMDS encoders and the per-channel serializers in the HDMI output path.

Parameters:
kLockStableCycles, 1024, PixelClk cycles synchronised lock must stay high before serializer reset is pulsed (>=2)
kSerdesRstCycles, 16, PixelClk cycles serializer reset is held asserted after lock qualifies (>=2)
kFlushCycles, 64, PixelClk cycles of control-token output after reset release before video (>=1)

Ports:
PixelClk  in  1  pixel clock; sole clock of the block
aRst  in  1  asynchronous, active-high reset
aLocked  in  1  clock-generator lock, asynchronous to PixelClk
pTmdsIn0  in  10  encoded word, channel 0 (blue)
pTmdsIn1  in  10  encoded word, channel 1 (green)
pTmdsIn2  in  10  encoded word, channel 2 (red)
pTmdsOut0  out  10  word to channel-0 serializer
pTmdsOut1  out  10  word to channel-1 serializer
pTmdsOut2  out  10  word to channel-2 serializer
pSerdesRst  out  1  reset to all serializers, active-high
pLinkUp  out  1  high while in RUN

Behaviour:
- aRst asserts asynchronously into WAIT_LOCK and clears all counters and synchroniser flops. Release takes effect on the next PixelClk edge.
- Reset values: pSerdesRst=1, pLinkUp=0, pTmdsOut0/1/2=CTRL_TOKEN_00 (10'b1101010100).
- aLocked passes through a 2-flop synchroniser to give pLockedS. All decisions use pLockedS, so there is 2 cycles of synchroniser latency.
- FSM states: WAIT_LOCK, STABLE, SRST, FLUSH, RUN. One counter is shared and cleared on every state entry.
- WAIT_LOCK: pSerdesRst=1, outputs are the token. Goes to STABLE when pLockedS=1.
- STABLE: pSerdesRst=1, counter increments. Goes to SRST when counter reaches kLockStableCycles-1.
- SRST: pSerdesRst=1 for exactly kSerdesRstCycles cycles, then goes to FLUSH.
- FLUSH: pSerdesRst=0, outputs are the token for exactly kFlushCycles cycles, then goes to RUN.
- RUN: pLinkUp=1. pTmdsOutN = pTmdsInN, registered, so there is 1 cycle of latency.
- Lock loss: pLockedS=0 in any state other than WAIT_LOCK forces WAIT_LOCK on the next edge and resets the counter. This takes priority over any simultaneous counter terminal event. pSerdesRst and the token output are asserted at that same edge.
- All outputs are registered. pSerdesRst, pLinkUp and the output-word select are decoded from the next state, so they change on the same edge as the state.
- Counter width is $clog2 of the largest parameter, plus 1. No wrap is possible because each terminal count forces an exit.
- Lock glitch shorter than 2 cycles: may be filtered by the synchroniser. If it is seen, the full sequence restarts.

Optional Feature:
- Macro HDMI_HPD_RESTART_EN.
- Defined: adds input aHpd (1 bit, async, sink hot-plug detect), 2-flop synchronised.
  - In RUN or FLUSH, pHpdS=0 forces WAIT_LOCK, the same as lock loss.
  - Leaving WAIT_LOCK requires pLockedS=1 AND pHpdS=1.
- Not defined: port absent; behaviour depends on lock only.

Decomposition:
- Package hdmi_pkg holds:
  - CTRL_TOKEN_00..11 constants (10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011)
  - TMDS word-width constant (10)
  - FSM state enum typedef
- Sub-module sync_2ff (width parameter): reused for aLocked and aHpd.

Test Plan:
- aRst=1 then release, aLocked=0 for 100 cycles -> pSerdesRst=1, pLinkUp=0, all outputs 10'b1101010100 throughout.
- aLocked rises at cycle T (defaults) -> pSerdesRst falls at T+2+1024+16 (±1 edge alignment, checked exactly against the model); token held 64 more cycles; pLinkUp=1 next; pTmdsOut0 follows pTmdsIn0=10'h2AA one cycle late.
- aLocked drops for 8 cycles during RUN -> within 3 cycles pLinkUp=0, pSerdesRst=1, token out; full sequence repeats after lock returns.
- aLocked drops on the exact cycle STABLE reaches terminal count (kLockStableCycles=4) -> goes to WAIT_LOCK, never SRST.
- aRst pulsed mid-FLUSH -> outputs return to reset values immediately, asynchronously; sequence restarts.
- With HDMI_HPD_RESTART_EN defined: aHpd=0 while locked -> stays in WAIT_LOCK; aHpd drops in RUN -> pLinkUp=0 within 3 cycles.
